// File: rtl/barrido_display.sv
// barrido_display
// Time-multiplexed scan controller for a common-anode multi-digit
// seven-segment display. A hex value is captured on a load strobe. The scan
// then drives one digit per slot, with a guard interval (all anodes off)
// before each slot, and can optionally suppress leading zeros.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   enable     1 = scan running, 0 = display off
//   load       single-cycle strobe, captures value_in into the shadow register
//   value_in   hex value to display (digit 0 = least significant nibble)
//   lz_blank   1 = suppress leading zeros
//   an         anode enables, active-low, at most one bit low
//   digit_hex  nibble for the external hex-to-7-segment decoder
//   digit_on   1 = current slot is lit (decoder output forced dark when 0)
//
// FSM states
//   state    | meaning
//   ST_OFF   | display dark, slot index and counter held at 0
//   ST_GUARD | all anodes off for BLANK_CYCLES between slots
//   ST_DRIVE | current digit driven for REFRESH_DIV cycles
module barrido_display #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value_in,
  input  logic                    lz_blank,
  output logic [N_DIGITS-1:0]     an,
  output logic [3:0]              digit_hex,
  output logic                    digit_on
);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [1:0]              state;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*N_DIGITS-1:0]   valor;

  logic [N_DIGITS-1:0]     blank;
  logic [N_DIGITS-1:0]     an_sel;
  logic [3:0]              nib_sel;
  logic                    blank_sel;
  logic                    guard_last;
  logic                    drive_last;
  logic [IW-1:0]           idx_next;

  // Leading-zero mask: walk from the most significant nibble down and keep
  // a running "everything above (and including) me is zero" flag.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank      = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (valor[4*i +: 4] == 4'h0);
      blank[i]   = lz_blank & upper_zero & (i != 0);
    end
  end

  // Per-slot selections done as explicit compares to avoid a variable part
  // select on the index.
  always_comb begin
    nib_sel   = 4'h0;
    blank_sel = 1'b0;
    an_sel    = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib_sel   = valor[4*i +: 4];
        blank_sel = blank[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  assign guard_last = (cnt == CW'(BLANK_CYCLES - 1));
  assign drive_last = (cnt == CW'(REFRESH_DIV - 1));
  assign idx_next   = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_OFF;
      cnt       <= '0;
      idx       <= '0;
      valor     <= '0;
      an        <= '1;
      digit_hex <= 4'h0;
      digit_on  <= 1'b0;
    end else begin
      // The shadow register is independent of the scan. A slot entry on the
      // same edge still sees the old value, because nib_sel reads valor
      // before this update lands.
      if (load)
        valor <= value_in;

      if (!enable) begin
        state    <= ST_OFF;
        cnt      <= '0;
        idx      <= '0;
        an       <= '1;
        digit_on <= 1'b0;
      end else begin
        case (state)
          ST_OFF: begin
            state <= ST_GUARD;
            cnt   <= '0;
            an    <= '1;
          end
          ST_GUARD: begin
            if (guard_last) begin
              state     <= ST_DRIVE;
              cnt       <= '0;
              digit_hex <= nib_sel;
              digit_on  <= ~blank_sel;
              an        <= blank_sel ? '1 : an_sel;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_DRIVE: begin
            if (drive_last) begin
              state <= ST_GUARD;
              cnt   <= '0;
              idx   <= idx_next;
              an    <= '1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= ST_OFF;
            cnt   <= '0;
            idx   <= '0;
            an    <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_barrido_display.sv
// Testbench for barrido_display with REFRESH_DIV=4, BLANK_CYCLES=1.
// The reference model tracks only the number of cycles since the scan was
// enabled and derives slot/phase from that with plain arithmetic.
module tb_barrido_display;

  localparam int ND   = 4;
  localparam int RD   = 4;
  localparam int BC   = 1;
  localparam int SLOT = RD + BC;
  localparam int PER  = ND * SLOT;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] value_in;
  logic        lz_blank;
  logic [3:0]  an;
  logic [3:0]  digit_hex;
  logic        digit_on;

  barrido_display #(
    .N_DIGITS    (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .load     (load),
    .value_in (value_in),
    .lz_blank (lz_blank),
    .an       (an),
    .digit_hex(digit_hex),
    .digit_on (digit_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [15:0] m_valor;
  int          m_k;
  logic [3:0]  m_an;
  logic [3:0]  m_hex;
  logic        m_on;

  typedef struct {
    logic        r;
    logic        e;
    logic        l;
    logic [15:0] v;
    logic        z;
    logic [3:0]  x_an;
    logic [3:0]  x_hex;
    logic        x_on;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [15:0] old;
    int p, s, q;
    if (rst) begin
      m_valor = 16'h0;
      m_k     = -1;
      m_an    = 4'hF;
      m_hex   = 4'h0;
      m_on    = 1'b0;
    end else begin
      old = m_valor;
      if (load) m_valor = value_in;
      if (!enable) begin
        m_k  = -1;
        m_an = 4'hF;
        m_on = 1'b0;
      end else begin
        m_k = m_k + 1;
        p = m_k % PER;
        s = p / SLOT;
        q = p % SLOT;
        if (q == BC) begin
          m_hex = 4'((old >> (4 * s)) & 16'hF);
          m_on  = !(lz_blank && (s != 0) && ((old >> (4 * s)) == 16'h0));
          m_an  = m_on ? ~(4'b0001 << s) : 4'hF;
        end else if (q < BC) begin
          m_an = 4'hF;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic l,
                      input logic [15:0] v, input logic z);
    rst      = r;
    enable   = e;
    load     = l;
    value_in = v;
    lz_blank = z;
    @(posedge clk);
    model_update();
    #1;
    check("model_an",  {12'h0, an},        {12'h0, m_an});
    check("model_hex", {12'h0, digit_hex}, {12'h0, m_hex});
    check("model_on",  {15'h0, digit_on},  {15'h0, m_on});
  endtask

  function automatic void add(input logic r, input logic e, input logic l,
                              input logic [15:0] v, input logic z,
                              input logic [3:0] xa, input logic [3:0] xh, input logic xo);
    vec_t t;
    t.r = r; t.e = e; t.l = l; t.v = v; t.z = z;
    t.x_an = xa; t.x_hex = xh; t.x_on = xo;
    tbl.push_back(t);
  endfunction

  initial begin
    rst = 1'b0; enable = 1'b0; load = 1'b0; value_in = 16'h0; lz_blank = 1'b0;
    m_valor = 16'h0; m_k = -1; m_an = 4'hF; m_hex = 4'h0; m_on = 1'b0;

    // reset, idle load, then basic scan of A3F0
    add(1, 0, 0, 16'h0000, 0, 4'hF, 4'h0, 0);
    add(1, 0, 0, 16'h0000, 0, 4'hF, 4'h0, 0);
    add(0, 0, 1, 16'h1234, 0, 4'hF, 4'h0, 0);
    add(0, 0, 0, 16'h0000, 0, 4'hF, 4'h0, 0);
    add(0, 0, 1, 16'hA3F0, 0, 4'hF, 4'h0, 0);
    add(0, 1, 0, 16'h0000, 0, 4'hF, 4'h0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 16'h0, 0, 4'hE, 4'h0, 1);
    add(0, 1, 0, 16'h0000, 0, 4'hF, 4'h0, 1);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 16'h0, 0, 4'hD, 4'hF, 1);
    add(0, 1, 0, 16'h0000, 0, 4'hF, 4'hF, 1);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 16'h0, 0, 4'hB, 4'h3, 1);
    add(0, 1, 0, 16'h0000, 0, 4'hF, 4'h3, 1);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 16'h0, 0, 4'h7, 4'hA, 1);
    add(0, 1, 0, 16'h0000, 0, 4'hF, 4'hA, 1);
    add(0, 1, 0, 16'h0000, 0, 4'hE, 4'h0, 1);

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].v, tbl[i].z);
      check("tbl_an",  {12'h0, an},        {12'h0, tbl[i].x_an});
      check("tbl_hex", {12'h0, digit_hex}, {12'h0, tbl[i].x_hex});
      check("tbl_on",  {15'h0, digit_on},  {15'h0, tbl[i].x_on});
    end

    // leading zeros: 0050, then 0000
    step(0, 0, 1, 16'h0050, 1);
    repeat (40) step(0, 1, 0, 16'h0, 1);
    step(0, 0, 1, 16'h0000, 1);
    step(0, 1, 0, 16'h0, 1);
    step(0, 1, 0, 16'h0, 1);
    check("lz_zero_digit0_an", {12'h0, an}, 16'h000E);
    check("lz_zero_digit0_hex", {12'h0, digit_hex}, 16'h0000);
    repeat (14) step(0, 1, 0, 16'h0, 1);
    check("lz_zero_slot3_dark", {12'h0, an}, 16'h000F);
    check("lz_zero_slot3_on", {15'h0, digit_on}, 16'h0000);

    // mid-slot load and load coincident with slot entry
    step(0, 0, 1, 16'h1234, 0);
    repeat (8) step(0, 1, 0, 16'h0, 0);
    step(0, 1, 1, 16'hFFFF, 0);
    check("midload_hold", {12'h0, digit_hex}, 16'h0003);
    step(0, 1, 0, 16'h0, 0);
    check("midload_hold_last", {12'h0, digit_hex}, 16'h0003);
    step(0, 1, 0, 16'h0, 0);
    step(0, 1, 0, 16'h0, 0);
    check("midload_next_slot", {12'h0, digit_hex}, 16'h000F);
    repeat (4) step(0, 1, 0, 16'h0, 0);
    step(0, 1, 1, 16'h5555, 0);
    check("coincident_old", {12'h0, digit_hex}, 16'h000F);
    check("coincident_an", {12'h0, an}, 16'h0007);
    repeat (4) step(0, 1, 0, 16'h0, 0);
    step(0, 1, 0, 16'h0, 0);
    check("coincident_new_next", {12'h0, digit_hex}, 16'h0005);

    // enable drop during slot-2 drive, then resume
    repeat (10) step(0, 1, 0, 16'h0, 0);
    check("pre_drop_slot2", {12'h0, an}, 16'h000B);
    step(0, 0, 0, 16'h0, 0);
    check("drop_off", {12'h0, an}, 16'h000F);
    step(0, 1, 0, 16'h0, 0);
    check("resume_guard", {12'h0, an}, 16'h000F);
    step(0, 1, 0, 16'h0, 0);
    check("resume_slot0", {12'h0, an}, 16'h000E);

    // reset during slot-3 drive
    repeat (15) step(0, 1, 0, 16'h0, 0);
    check("pre_rst_slot3", {12'h0, an}, 16'h0007);
    step(1, 1, 0, 16'h0, 0);
    check("rst_an", {12'h0, an}, 16'h000F);
    check("rst_hex", {12'h0, digit_hex}, 16'h0000);
    check("rst_on", {15'h0, digit_on}, 16'h0000);
    step(0, 1, 0, 16'h0, 0);
    step(0, 1, 0, 16'h0, 0);
    check("post_rst_digit0", {12'h0, an}, 16'h000E);
    check("post_rst_hex0", {12'h0, digit_hex}, 16'h0000);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic r, e, l, z;
      logic [15:0] v;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 39) != 0);
      l = ($urandom_range(0, 9) == 0);
      z = ($urandom_range(0, 63) == 0) ? ~lz_blank : lz_blank;
      case ($urandom_range(0, 3))
        0:       v = 16'(($urandom_range(0, 15)) << (4 * $urandom_range(0, 3)));
        1:       v = 16'h0000;
        default: v = 16'($urandom);
      endcase
      step(r, e, l, v, z);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/barrido_display.md
# barrido_display

Time-multiplexed scan controller for the board's common-anode 4-digit seven-segment display. It captures a 16-bit hex value on a load strobe and sequences one digit at a time onto the shared segment bus. For each slot it presents the digit's nibble to the hex-to-7-segment decoder and drives one active-low anode, with optional leading-zero suppression. Sits between the datapath result register and the decoder/pin outputs.

## Interface
- N_DIGITS, 4, number of digits scanned (digit 0 = least significant nibble, anode bit 0)
- REFRESH_DIV, 50000, clock cycles a digit is driven per slot (must be ≥ 1)
- BLANK_CYCLES, 500, anti-ghosting guard cycles with all anodes off between slots (must be ≥ 1)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = scan running, 0 = display off
- load  in  1  single-cycle strobe; capture value_in
- value_in  in  4*N_DIGITS  hex value to display
- lz_blank  in  1  1 = suppress leading zeros
- an  out  N_DIGITS  anode enables, active-low, exactly one or zero bits low
- digit_hex  out  4  nibble for the decoder, registered
- digit_on  out  1  1 = current slot is lit; decoder output must be forced to 7'b1111111 when 0

## Operation
- Shadow register `valor` captures value_in on the clock edge where load=1. This happens regardless of enable.
- Leading-zero mask is computed from `valor`. Digit i is blanked when lz_blank=1 and all nibbles i..N_DIGITS-1 are 0. Digit 0 is never blanked, so value 0 shows "0".
- FSM states:
  - OFF: an all 1, digit_on=0, slot index idx=0, counter=0.
  - GUARD: an all 1, counter counts BLANK_CYCLES cycles.
  - DRIVE: an[idx]=0 unless the digit is blanked, counter counts REFRESH_DIV cycles.
- Transitions:
  - OFF→GUARD when enable=1.
  - GUARD→DRIVE after the last guard cycle. On this edge digit_hex←valor[4*idx+:4] and digit_on←!blank(idx).
  - DRIVE→GUARD after the last drive cycle. On this edge idx←idx+1, wrapping N_DIGITS-1→0.
  - Any state→OFF when enable=0. idx resets to 0 on this transition.
- digit_hex and digit_on are latched only on slot entry. A load arriving mid-slot changes the display starting from the next slot; there is no tearing within a slot.
- load and GUARD→DRIVE on the same edge: the slot latches the old `valor`. The new value applies from the next slot.
- Counter width is $clog2(max(REFRESH_DIV, BLANK_CYCLES)). It is a terminal-count compare with no overflow. The counter clears on every state change.

## Timing
- Reset values: an='1 (all off), digit_hex=0, digit_on=0, valor=0, idx=0, counter=0, state=OFF. rst takes priority over enable and load.
- rst asserted mid-slot: the next edge yields the reset values and the anodes turn off immediately.
- Edge sequence from enable rising at edge E (the first edge where enable=1 is sampled):
  - GUARD occupies edges E..E+BLANK_CYCLES-1.
  - an[0] goes low after edge E+BLANK_CYCLES (when lit).
  - an[0] stays low for REFRESH_DIV cycles.
- Full scan period is N_DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.
- Load-to-visible latency is at most one slot plus one guard interval.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Test parameters for all scenarios: REFRESH_DIV=4, BLANK_CYCLES=1.
- Reset/idle: rst=1 for 2 cycles, enable=0 → an=4'b1111, digit_hex=0, digit_on=0 on every cycle; load of 16'h1234 changes no output.
- Basic scan: load 16'hA3F0, lz_blank=0, enable=1 → repeating pattern of 1 cycle an=1111, then 4 cycles an=1110 with digit_hex=0, then 1 cycle guard, then 4 cycles an=1101 with digit_hex=F, then 1110…→1011 with digit_hex=3, then 0111 with digit_hex=A; period 20 cycles.
- Leading zeros: load 16'h0050, lz_blank=1 → slots 0 and 1 lit (digit_hex 0, 5); slots 2 and 3 keep an=1111 with digit_on=0. Load 16'h0000 → only digit 0 lit, showing 0.
- Mid-slot load: during the slot-1 drive, load 16'hFFFF → remainder of slot 1 keeps the old nibble; slot 2 shows F. Load coincident with slot entry → that slot shows the old nibble.
- Enable drop/resume: deassert enable during the slot-2 drive → an=1111 next cycle; reassert → 1 guard cycle, then slot 0.
- Reset mid-operation: rst pulse during the slot-3 drive → next cycle all reset values; valor=0, and after re-enable digit 0 shows 0.
